get_fsm: RTL and testbench

- Read-side sub-FSM of the cache controller, counterpart to the upsert sub-FSM.
- On a GET, takes the key-match result (hit, one-hot idx_in) from the key CAM and drives a read select to the value store.
- Waits a fixed read latency, then captures the value and presents it on a valid/ready response handshake.
- Reports completion or error to the top controller via sub_cmd_t; the top controller uses enter to start it and en to gate it.

---
 rtl/get_fsm.sv | 141 ++++++++++++++
 tb/tb_get_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/get_fsm.sv
// get_fsm: read-side sub-FSM of the cache controller (key match -> value fetch -> response).
// Optional miss/error counter port enabled by defining GET_MISS_COUNT_EN.
package ctrl_types_pkg;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  typedef enum logic [1:0] {
    GET_ST_START = 2'd0,
    GET_ST_WAIT  = 2'd1,
    GET_ST_RESP  = 2'd2
  } get_substate_e;

endpackage

module get_fsm
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES  = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   enter,
  input  logic                   hit,
  input  logic [NUM_ENTRIES-1:0] idx_in,
  input  logic [DATA_WIDTH-1:0]  rd_data_in,
  input  logic                   resp_ready,
  output logic                   select_out,
  output logic                   read_out,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic [DATA_WIDTH-1:0]  value_out,
  output logic                   value_valid,
`ifdef GET_MISS_COUNT_EN
  output logic [15:0]            miss_count,
`endif
  output sub_cmd_t               cmd
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  get_substate_e           state_q, state_d;
  logic [2:0]              lat_q, lat_d;
  logic [NUM_ENTRIES-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   value_q, value_d;
  logic                    idx_onehot;
  logic                    idx_ok;

  assign idx_onehot = (idx_in != '0) &&
    ((idx_in & (idx_in - NUM_ENTRIES'(1))) == '0);
  assign idx_ok = hit && idx_onehot;
  assign value_out = value_q;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    idx_d       = idx_q;
    value_d     = value_q;
    select_out  = 1'b0;
    read_out    = 1'b0;
    idx_out     = '0;
    value_valid = 1'b0;
    cmd         = '0;

    unique case (state_q)
      GET_ST_START: begin
        if (en) begin
          if (idx_ok) begin
            select_out = 1'b1;
            read_out   = 1'b1;
            idx_out    = idx_in;
            idx_d      = idx_in;
            lat_d      = LAT_INIT;
            state_d    = GET_ST_WAIT;
          end else begin
            cmd.error = 1'b1;
          end
        end
      end
      GET_ST_WAIT: begin
        select_out = 1'b1;
        read_out   = 1'b1;
        idx_out    = idx_q;
        if (en) begin
          if (lat_q != 3'd0) begin
            lat_d = lat_q - 3'd1;
          end else begin
            value_d = rd_data_in;
            state_d = GET_ST_RESP;
          end
        end
      end
      GET_ST_RESP: begin
        value_valid = 1'b1;
        if (en && resp_ready) begin
          cmd.done = 1'b1;
          state_d  = GET_ST_START;
        end
      end
      default: state_d = GET_ST_START;
    endcase

    // restart wins over everything; the held value survives an abort
    if (enter) begin
      state_d = GET_ST_START;
      lat_d   = 3'd0;
      idx_d   = idx_q;
      value_d = value_q;
      cmd     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_ST_START;
      lat_q   <= 3'd0;
      idx_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      value_q <= value_d;
    end
  end

`ifdef GET_MISS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= 16'd0;
    end else if (cmd.error && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_get_fsm.sv
// tb_get_fsm: scoreboard bench for get_fsm.
// Stimulus pushes expected done/error events; a negedge monitor pops them.
module tb_get_fsm;
  import ctrl_types_pkg::*;

  localparam int NE  = 16;
  localparam int DW  = 64;
  localparam int LAT = 3;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          enter = 1'b0;
  logic          hit = 1'b0;
  logic [NE-1:0] idx_in = '0;
  logic [DW-1:0] rd_data_in = '0;
  logic          resp_ready = 1'b0;
  logic          select_out;
  logic          read_out;
  logic [NE-1:0] idx_out;
  logic [DW-1:0] value_out;
  logic          value_valid;
  sub_cmd_t      cmd;
`ifdef GET_MISS_COUNT_EN
  logic [15:0]   miss_count;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  get_fsm #(
    .NUM_ENTRIES (NE),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(LAT)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .enter      (enter),
    .hit        (hit),
    .idx_in     (idx_in),
    .rd_data_in (rd_data_in),
    .resp_ready (resp_ready),
    .select_out (select_out),
    .read_out   (read_out),
    .idx_out    (idx_out),
    .value_out  (value_out),
    .value_valid(value_valid),
`ifdef GET_MISS_COUNT_EN
    .miss_count (miss_count),
`endif
    .cmd        (cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (cmd.done || cmd.error)) begin
      if (sb.size() == 0) begin
        chk("unexpected_cmd", {62'd0, cmd.done, cmd.error}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cmd_kind", {62'd0, cmd.done, cmd.error},
            {62'd0, ~e.err, e.err});
        if (cmd.done) begin
          chk("resp_data", value_out, e.data);
          chk("resp_hs", {63'd0, value_valid & resp_ready}, 64'd1);
        end
      end
    end
  end

  task automatic do_get(input logic [NE-1:0] idx, input logic [DW-1:0] d,
                        input int en_gap, input int rdy_wait);
    int  sel;
    bit  got;
    sel = 1;
    got = 1'b0;
    en = 1'b1;
    hit = 1'b1;
    idx_in = idx;
    rd_data_in = d;
    resp_ready = (rdy_wait == 0);
    sb.push_back('{err: 1'b0, data: d});
    @(negedge clk);
    chk("start_sel", {63'd0, select_out & read_out}, 64'd1);
    chk("start_idx", DW'(idx_out), DW'(idx));
    tick();
    hit = 1'b0;
    idx_in = '0;
    if (en_gap > 0) begin
      en = 1'b0;
      for (int i = 0; i < en_gap; i++) begin
        @(negedge clk);
        if (select_out) sel++;
        tick();
      end
      en = 1'b1;
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (value_valid) begin
        got = 1'b1;
        break;
      end
      if (select_out) sel++;
      chk("wait_idx", DW'(idx_out), DW'(idx));
      tick();
    end
    chk("resp_timeout", {63'd0, got}, 64'd1);
    chk("sel_cycles", DW'(sel), DW'(LAT + 1 + en_gap));
    chk("resp_value", value_out, d);
    if (rdy_wait > 0) begin
      chk("early_done", {63'd0, cmd.done}, 64'd0);
      for (int i = 1; i < rdy_wait; i++) begin
        tick();
        @(negedge clk);
        chk("bp_valid", {63'd0, value_valid}, 64'd1);
        chk("bp_stable", value_out, d);
        chk("bp_no_done", {63'd0, cmd.done}, 64'd0);
      end
      tick();
      resp_ready = 1'b1;
      @(negedge clk);
      chk("done_pulse", {63'd0, cmd.done}, 64'd1);
    end
    tick();
    resp_ready = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("after_valid", {63'd0, value_valid}, 64'd0);
    tick();
  endtask

  task automatic do_err(input logic h, input logic [NE-1:0] idx,
                        input string name);
    en = 1'b1;
    hit = h;
    idx_in = idx;
    sb.push_back('{err: 1'b1, data: '0});
    @(negedge clk);
    chk({name, "_nosel"}, {63'd0, select_out}, 64'd0);
    chk({name, "_err"}, {63'd0, cmd.error}, 64'd1);
    tick();
    en = 1'b0;
    hit = 1'b0;
    idx_in = '0;
    @(negedge clk);
    chk({name, "_one_cyc"}, {63'd0, cmd.error}, 64'd0);
    chk({name, "_start"}, {62'd0, value_valid, select_out}, 64'd0);
    tick();
  endtask

  initial begin
    #12;
    chk("rst_sel", {63'd0, select_out}, 64'd0);
    chk("rst_read", {63'd0, read_out}, 64'd0);
    chk("rst_idx", DW'(idx_out), 64'd0);
    chk("rst_value", value_out, 64'd0);
    chk("rst_valid", {63'd0, value_valid}, 64'd0);
    chk("rst_cmd", {62'd0, cmd}, 64'd0);
`ifdef GET_MISS_COUNT_EN
    chk("rst_miss", DW'(miss_count), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    do_get(16'h0008, 64'hDEAD_BEEF_0000_0001, 0, 0);

    do_err(1'b0, 16'h0000, "miss");
`ifdef GET_MISS_COUNT_EN
    chk("miss_cnt1", DW'(miss_count), 64'd1);
`endif
    do_err(1'b1, 16'h0011, "multihot");
    do_err(1'b1, 16'h0000, "zeroidx");
`ifdef GET_MISS_COUNT_EN
    chk("miss_cnt3", DW'(miss_count), 64'd3);
`endif

    do_get(16'h0100, 64'h1234_5678_9ABC_DEF0, 2, 5);

    // abort in RESP with the consumer ready
    en = 1'b1;
    hit = 1'b1;
    idx_in = 16'h0002;
    rd_data_in = 64'hCAFE_0000_0000_0002;
    tick();
    hit = 1'b0;
    idx_in = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (value_valid) break;
      tick();
    end
    chk("abort_in_resp", {63'd0, value_valid}, 64'd1);
    tick();
    enter = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("abort_no_done", {63'd0, cmd.done}, 64'd0);
    tick();
    enter = 1'b0;
    resp_ready = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("abort_valid", {63'd0, value_valid}, 64'd0);
    chk("abort_keep", value_out, 64'hCAFE_0000_0000_0002);
    tick();

    // async reset while waiting on the value store
    en = 1'b1;
    hit = 1'b1;
    idx_in = 16'h0004;
    rd_data_in = 64'h5555_AAAA_5555_AAAA;
    tick();
    hit = 1'b0;
    idx_in = '0;
    @(negedge clk);
    chk("pre_rst_sel", {63'd0, select_out}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", {63'd0, select_out}, 64'd0);
    chk("arst_read", {63'd0, read_out}, 64'd0);
    chk("arst_idx", DW'(idx_out), 64'd0);
    chk("arst_value", value_out, 64'd0);
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    do_get(16'h8000, 64'h0BAD_F00D_0000_8000, 0, 0);

    tick();
    chk("sb_empty", DW'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
